// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - shared format codes, RV32I opcodes and loader FSM states
package rv_enc_pkg;

    // Instruction format selector carried on req_fmt; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Major opcodes understood by the core's control decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rv_instr_pack.sv
// rtl/rv_instr_pack.sv - combinational RV32I field packer with illegal-request flag
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the field layout for the format; unused fields never reach the word
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = imm[0];
            end
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - streams encoded RV32I words into imem for the boot loader
module rv32i_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter  int MAX_WORDS = 256,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             finish,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fmt,
    input  logic [6:0]       req_opcode,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [31:0]      req_imm,
    output logic [31:0]      iaddr,
    output logic [31:0]      iwdata,
    output logic [3:0]       iwe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic             err
);

    state_e       state;
    logic [31:0]  enc_word;
    logic         enc_illegal;
    logic         inflight;
    logic         accept;
    logic         last_slot;
    logic [CNT_W:0] occupancy;

    rv_instr_pack u_pack (
        .fmt     (req_fmt),
        .opcode  (req_opcode),
        .funct3  (req_funct3),
        .funct7  (req_funct7),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // A write is in flight exactly in the cycle iwe is asserted
    always_comb begin
        inflight  = (iwe != 4'b0000);
        occupancy = {1'b0, word_count} + (CNT_W + 1)'(inflight);
        last_slot = (word_count == CNT_W'(MAX_WORDS - 1));
        busy      = (state == ST_LOAD);
        done      = (state == ST_DONE);
        req_ready = busy && !finish && (occupancy < (CNT_W + 1)'(MAX_WORDS));
        accept    = req_valid && req_ready;
    end

    // Session FSM plus write pipeline: accept registers the word, the following
    // edge retires it by advancing the slot address and the word count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            iaddr      <= '0;
            iwdata     <= '0;
            iwe        <= 4'b0000;
            word_count <= '0;
            err        <= 1'b0;
        end else if (start) begin
            state      <= ST_LOAD;
            iaddr      <= base_addr & ~32'd3;
            iwe        <= 4'b0000;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            iwe <= 4'b0000;
            if (inflight) begin
                iaddr      <= iaddr + 32'd4;
                word_count <= word_count + CNT_W'(1);
            end
            if (accept) begin
                if (enc_illegal) begin
                    err <= 1'b1;
                end else begin
                    iwe    <= 4'b1111;
                    iwdata <= enc_word;
                end
            end
            if (state == ST_LOAD && (finish || (inflight && last_slot))) begin
                state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - randomized and directed self-checking bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;
    import rv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_fmt = '0;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;

    logic        req_ready, busy, done, err;
    logic [31:0] iaddr, iwdata;
    logic [3:0]  iwe;
    logic [8:0]  word_count;

    logic        req_ready4, busy4, done4, err4;
    logic [31:0] iaddr4, iwdata4;
    logic [3:0]  iwe4;
    logic [2:0]  word_count4;

    int n_err = 0;
    int n_checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr;
    int          n_legal;
    logic        exp_err;
    int          writes4 = 0;

    always #5 clk = ~clk;

    rv32i_instr_encoder u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt), .req_opcode(req_opcode),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .iaddr(iaddr), .iwdata(iwdata), .iwe(iwe),
        .busy(busy), .done(done), .word_count(word_count), .err(err)
    );

    rv32i_instr_encoder #(.MAX_WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready4), .req_fmt(req_fmt), .req_opcode(req_opcode),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_imm(req_imm), .iaddr(iaddr4), .iwdata(iwdata4), .iwe(iwe4),
        .busy(busy4), .done(done4), .word_count(word_count4), .err(err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference encoding from the RV32I bit-placement rules, using shifts and masks
    function automatic logic [32:0] ref_encode(input int unsigned fmt, input int unsigned op,
                                               input int unsigned f3, input int unsigned f7,
                                               input int unsigned rd, input int unsigned rs1,
                                               input int unsigned rs2, input int unsigned imm);
        int unsigned w;
        bit bad;
        bad = 0;
        w = 0;
        case (fmt)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            2: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
            3: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
                bad = (imm & 1) != 0;
            end
            4: w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
                bad = (imm & 1) != 0;
            end
            default: bad = 1;
        endcase
        return {bad, w};
    endfunction

    task automatic model_accept();
        logic [32:0] r;
        r = ref_encode(req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm);
        if (r[32]) begin
            exp_err = 1'b1;
        end else begin
            exp_q.push_back({exp_addr, r[31:0]});
            exp_addr = exp_addr + 32'd4;
            n_legal++;
        end
    endtask

    // Write monitor: every imem write must match the next expected word in order
    always @(negedge clk) begin
        logic [63:0] e;
        if (iwe !== 4'b0000) begin
            check("iwe_mask", iwe, 4'hF);
            wr_addr_q.push_back(iaddr);
            wr_data_q.push_back(iwdata);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("waddr", iaddr, e[63:32]);
                check("wdata", iwdata, e[31:0]);
            end
        end
        if (iwe4 !== 4'b0000) writes4++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = base & ~32'd3;
        n_legal = 0;
        exp_err = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bit ok;
        req_fmt = f; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                model_accept();
                break;
            end
            @(posedge clk);
            #1;
        end
        check("accept", 32'(ok), 1);
        if (!ok) req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [31:0] a0;
        logic [31:0] b0;
        int acc4;
        logic r4 [10];

        #2 reset = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_iwdata", iwdata, 0);
        check("rst_iwe", 32'(iwe), 0);
        check("rst_count", 32'(word_count), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);

        // addi x1,x0,5
        do_start(32'h100);
        check("start_busy", 32'(busy), 1);
        check("start_iaddr", iaddr, 32'h100);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b0;
        step(2);
        check("addi_word", wr_data_q[$], 32'h00500093);
        check("addi_addr", wr_addr_q[$], 32'h100);
        check("addi_count", 32'(word_count), 1);
        check("addi_next", iaddr, 32'h104);

        // add then sw back-to-back
        do_start(32'h100);
        n0 = wr_data_q.size();
        send(FMT_R, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF);
        send(FMT_S, OP_STORE, 3'd2, 7'h7F, 5'd31, 5'd1, 5'd2, 32'd8);
        req_valid = 1'b0;
        step(2);
        check("b2b_nwrites", wr_data_q.size(), n0 + 2);
        check("add_word", wr_data_q[n0], 32'h002081B3);
        check("add_addr", wr_addr_q[n0], 32'h100);
        check("sw_word", wr_data_q[n0 + 1], 32'h0020A423);
        check("sw_addr", wr_addr_q[n0 + 1], 32'h104);
        check("b2b_count", 32'(word_count), 2);

        // branch, jump, upper
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        req_valid = 1'b0; step(2);
        check("beq_word", wr_data_q[$], 32'h00208463);
        send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16);
        req_valid = 1'b0; step(2);
        check("jal_word", wr_data_q[$], 32'h010000EF);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        req_valid = 1'b0; step(2);
        check("lui_word", wr_data_q[$], 32'h123452B7);
        check("err_clean", 32'(err), 0);

        // rejects: fmt 7 and misaligned branch
        a0 = iaddr;
        n0 = wr_data_q.size();
        send(3'd7, OP_R, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        req_valid = 1'b0; step(2);
        check("rej_nowrite", wr_data_q.size(), n0);
        check("rej_iaddr", iaddr, a0);
        check("rej_err", 32'(err), 1);
        send(FMT_I, OP_LOAD, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFC);
        req_valid = 1'b0; step(2);
        check("rej_nextaddr", wr_addr_q[$], a0);

        // randomized session, unaligned base
        b0 = $urandom();
        do_start(b0);
        check("rand_base", iaddr, b0 & ~32'd3);
        for (int k = 0; k < 40; k++) begin
            send(3'($urandom_range(0, 7)), 7'($urandom()), 3'($urandom()), 7'($urandom()),
                 5'($urandom()), 5'($urandom()), 5'($urandom()), $urandom());
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                step(1);
            end
        end
        req_valid = 1'b0;
        step(3);
        check("rand_count", 32'(word_count), 32'(n_legal));
        check("rand_err", 32'(err), 32'(exp_err));
        check("rand_iaddr", iaddr, (b0 & ~32'd3) + 32'(4 * n_legal));

        // MAX_WORDS=4 instance with valid held high
        do_start(32'h2000);
        n0 = writes4;
        acc4 = 0;
        req_fmt = FMT_I; req_opcode = OP_IMM; req_funct3 = 3'd0; req_funct7 = 7'd0;
        req_rd = 5'd7; req_rs1 = 5'd7; req_rs2 = 5'd0; req_imm = 32'd1;
        req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            r4[c] = req_ready4;
            if (req_ready4) acc4++;
            if (req_ready) model_accept();
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        step(3);
        check("max_accepts", 32'(acc4), 4);
        check("max_ready_after4", 32'(r4[4]), 0);
        check("max_writes", 32'(writes4 - n0), 4);
        check("max_done", 32'(done4), 1);
        check("max_count", 32'(word_count4), 4);
        check("max_iaddr", iaddr4, 32'h2010);

        // finish while a write is in flight, with a request offered at the same time
        do_start(32'h300);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd9);
        check("fin_iwe", 32'(iwe), 32'hF);
        finish = 1'b1;
        req_fmt = FMT_U; req_imm = 32'hABCDE000;
        #1;
        check("fin_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        finish = 1'b0;
        check("fin_done", 32'(done), 1);
        check("fin_count", 32'(word_count), 1);
        check("fin_lastaddr", wr_addr_q[$], 32'h300);
        check("fin_done_ready", 32'(req_ready), 0);
        req_valid = 1'b0;
        step(2);
        check("fin_hold_iaddr", iaddr, 32'h304);

        // reset during a back-to-back stream
        do_start(32'h400);
        req_fmt = FMT_I; req_imm = 32'd3;
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (req_ready) model_accept();
            @(posedge clk);
            #1;
        end
        check("rst2_pre_iwe", 32'(iwe), 32'hF);
        reset = 1'b1;
        #1;
        exp_q.delete();
        n0 = wr_data_q.size();
        check("rst2_iwe", 32'(iwe), 0);
        check("rst2_iaddr", iaddr, 0);
        check("rst2_iwdata", iwdata, 0);
        check("rst2_count", 32'(word_count), 0);
        check("rst2_ready", 32'(req_ready), 0);
        check("rst2_busy", 32'(busy), 0);
        step(3);
        check("rst2_nowrite", wr_data_q.size(), n0);
        reset = 1'b0;
        req_valid = 1'b0;
        step(2);
        check("rst2_idle_ready", 32'(req_ready), 0);

        check("exp_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
